// File: rtl/result_capture_ctrl_if.sv
// Handshake bundle between the filter output stream, the result RAM and the
// display browser. The master side drives the stream and buttons.
interface result_capture_ctrl_if #(
  parameter int data_bits = 8,
  parameter int addr_bits = 8
);
  logic                 start;
  logic                 in_valid;
  logic [data_bits-1:0] in_data;
  logic                 step_up;
  logic                 step_down;
  logic                 ram_we;
  logic [addr_bits-1:0] ram_waddr;
  logic [data_bits-1:0] ram_wdata;
  logic [addr_bits-1:0] ram_raddr;
  logic [addr_bits-1:0] count;
  logic                 busy;
  logic                 done;

  modport master (
    output start, in_valid, in_data, step_up, step_down,
    input  ram_we, ram_waddr, ram_wdata, ram_raddr, count, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, step_up, step_down,
    output ram_we, ram_waddr, ram_wdata, ram_raddr, count, busy, done
  );
endinterface

// File: rtl/result_capture_ctrl.sv
// Captures DEPTH filter results into RAM after dropping WARMUP warm-up samples,
// and owns the display browse pointer that wraps within the captured range.
//
// state | meaning
// IDLE  | waiting for start after reset
// WARM  | dropping the first WARMUP valid samples
// CAP   | writing valid samples to RAM at address count
// DONE  | DEPTH results captured, waiting for a restart
module result_capture_ctrl #(
  parameter int data_bits = 8,
  parameter int addr_bits = 8,
  parameter int DEPTH     = 255,
  parameter int WARMUP    = 4
) (
  input logic                  clk,
  input logic                  rst,
  result_capture_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WARM, CAP, DONE} state_t;

  localparam logic [addr_bits-1:0] addr_one = 1;

  state_t               state;
  logic                 ram_we_q;
  logic [addr_bits-1:0] ram_waddr_q;
  logic [data_bits-1:0] ram_wdata_q;
  logic [addr_bits-1:0] ram_raddr_q;
  logic [addr_bits-1:0] count_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 start_go;
  logic                 warm_last;

  assign start_go = bus.start && (state == IDLE || state == DONE);

  generate
    if (WARMUP > 0) begin : g_warm
      localparam int warm_bits = $clog2(WARMUP + 1);
      logic [warm_bits-1:0] warm_cnt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          warm_cnt <= '0;
        else if (start_go)
          warm_cnt <= '0;
        else if (state == WARM && bus.in_valid)
          warm_cnt <= warm_cnt + warm_bits'(1);
      end

      assign warm_last = (state == WARM) && bus.in_valid &&
                         (warm_cnt == warm_bits'(WARMUP - 1));
    end else begin : g_no_warm
      assign warm_last = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            count_q <= '0;
            state   <= (WARMUP > 0) ? WARM : CAP;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        WARM: begin
          if (warm_last)
            state <= CAP;
        end
        CAP: begin
          if (bus.in_valid) begin
            ram_we_q    <= 1'b1;
            ram_waddr_q <= count_q;
            ram_wdata_q <= bus.in_data;
            count_q     <= count_q + addr_one;
            if (count_q == addr_bits'(DEPTH - 1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Wrap is modulo the captured count, using the count from before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ram_raddr_q <= '0;
    else if (start_go)
      ram_raddr_q <= '0;
    else if (count_q != '0 && (bus.step_up ^ bus.step_down)) begin
      if (bus.step_up)
        ram_raddr_q <= (ram_raddr_q == count_q - addr_one) ? '0 : ram_raddr_q + addr_one;
      else
        ram_raddr_q <= (ram_raddr_q == '0) ? count_q - addr_one : ram_raddr_q - addr_one;
    end
  end

  assign bus.ram_we    = ram_we_q;
  assign bus.ram_waddr = ram_waddr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_raddr = ram_raddr_q;
  assign bus.count     = count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_result_capture_ctrl.sv
// Drives two capture controllers (WARMUP=4/DEPTH=8 and WARMUP=0/DEPTH=1) from
// one stimulus stream and checks every output every cycle against a step model.
module tb_result_capture_ctrl;
  localparam int DB      = 8;
  localparam int AB      = 8;
  localparam int A_WARM  = 4;
  localparam int A_DEPTH = 8;
  localparam int B_WARM  = 0;
  localparam int B_DEPTH = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DB-1:0] in_data = '0;
  logic          step_up = 1'b0;
  logic          step_down = 1'b0;

  always #5 clk = ~clk;

  result_capture_ctrl_if #(.data_bits(DB), .addr_bits(AB)) ifa ();
  result_capture_ctrl_if #(.data_bits(DB), .addr_bits(AB)) ifb ();

  assign ifa.start     = start;
  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.step_up   = step_up;
  assign ifa.step_down = step_down;
  assign ifb.start     = start;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.step_up   = step_up;
  assign ifb.step_down = step_down;

  result_capture_ctrl #(.data_bits(DB), .addr_bits(AB), .DEPTH(A_DEPTH), .WARMUP(A_WARM))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  result_capture_ctrl #(.data_bits(DB), .addr_bits(AB), .DEPTH(B_DEPTH), .WARMUP(B_WARM))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // phase: 0 idle, 1 discarding warm-up samples, 2 capturing, 3 complete
  typedef struct {
    int phase;
    int warm_left;
    int cnt;
    int raddr;
    int we;
    int waddr;
    int wdata;
  } mdl_t;

  mdl_t ma, mb;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   qa[$];
  int   qb[$];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.phase = 0; r.warm_left = 0; r.cnt = 0; r.raddr = 0;
    r.we = 0; r.waddr = 0; r.wdata = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int warmup, int depth,
                                    bit st, bit v, int d, bit up, bit dn);
    mdl_t n;
    bit   go;
    n = m;
    n.we = 0;
    go = st && (m.phase == 0 || m.phase == 3);
    if (go)
      n.raddr = 0;
    else if (m.cnt > 0 && up != dn)
      n.raddr = up ? (m.raddr + 1) % m.cnt : (m.raddr + m.cnt - 1) % m.cnt;
    if (go) begin
      n.cnt = 0;
      n.warm_left = warmup;
      n.phase = (warmup > 0) ? 1 : 2;
    end else if (m.phase == 1 && v) begin
      n.warm_left = m.warm_left - 1;
      if (n.warm_left == 0) n.phase = 2;
    end else if (m.phase == 2 && v) begin
      n.we = 1;
      n.waddr = m.cnt;
      n.wdata = d;
      n.cnt = m.cnt + 1;
      if (n.cnt == depth) n.phase = 3;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= mdl_reset();
      mb <= mdl_reset();
    end else begin
      ma <= mdl_step(ma, A_WARM, A_DEPTH, start, in_valid, int'(in_data), step_up, step_down);
      mb <= mdl_step(mb, B_WARM, B_DEPTH, start, in_valid, int'(in_data), step_up, step_down);
    end
  end

  task automatic chk(string nm, logic [31:0] act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp_out(string tag, logic we, logic [AB-1:0] waddr, logic [DB-1:0] wdata,
                         logic [AB-1:0] raddr, logic [AB-1:0] cnt, logic busy, logic done,
                         mdl_t m);
    chk({tag, "_ram_we"}, {31'd0, we}, m.we);
    chk({tag, "_ram_waddr"}, {24'd0, waddr}, m.waddr);
    chk({tag, "_ram_wdata"}, {24'd0, wdata}, m.wdata);
    chk({tag, "_ram_raddr"}, {24'd0, raddr}, m.raddr);
    chk({tag, "_count"}, {24'd0, cnt}, m.cnt);
    chk({tag, "_busy"}, {31'd0, busy}, (m.phase == 1 || m.phase == 2) ? 1 : 0);
    chk({tag, "_done"}, {31'd0, done}, (m.phase == 3) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    cyc++;
    cmp_out("a", ifa.ram_we, ifa.ram_waddr, ifa.ram_wdata, ifa.ram_raddr, ifa.count,
            ifa.busy, ifa.done, ma);
    cmp_out("b", ifb.ram_we, ifb.ram_waddr, ifb.ram_wdata, ifb.ram_raddr, ifb.count,
            ifb.busy, ifb.done, mb);
    if (ifa.ram_we === 1'b1) qa.push_back(int'(ifa.ram_waddr) * 256 + int'(ifa.ram_wdata));
    if (ifb.ram_we === 1'b1) qb.push_back(int'(ifb.ram_waddr) * 256 + int'(ifb.ram_wdata));
  end

  task automatic drive(bit st, bit v, int d, bit up, bit dn);
    start = st; in_valid = v; in_data = DB'(d); step_up = up; step_down = dn;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; step_up = 1'b0; step_down = 1'b0;
  endtask

  // Expected log: (k, first+k) for k = 0..A_DEPTH-1
  task automatic check_log_a(string nm, int first);
    chk({nm, "_nwrites"}, qa.size(), A_DEPTH);
    for (int k = 0; k < A_DEPTH && k < qa.size(); k++)
      chk({nm, "_write"}, qa[k], k * 256 + first + k);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int exp_up[9];
    int idx;
    int guard;
    bit v, st, up, dn;
    exp_up = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_count_a", ifa.count, 0);
    chk("reset_we_a", ifa.ram_we, 0);
    chk("reset_busy_a", ifa.busy, 0);
    chk("reset_done_a", ifa.done, 0);
    rst = 1'b1;
    @(negedge clk);

    // Run 1: contiguous samples 10..21
    drive(1, 0, 0, 0, 0);
    chk("run1_busy_after_start", ifa.busy, 1);
    for (int i = 10; i <= 21; i++) drive(0, 1, i, 0, 0);
    chk("run1_last_we", ifa.ram_we, 1);
    chk("run1_last_waddr", ifa.ram_waddr, 7);
    chk("run1_done", ifa.done, 1);
    chk("run1_count", ifa.count, 8);
    drive(0, 0, 0, 0, 0);
    check_log_a("run1", 14);

    // Browse within the 8 captured results
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 0, 1, 0);
      chk("browse_up", ifa.ram_raddr, exp_up[k]);
    end
    drive(0, 0, 0, 0, 1);
    chk("browse_down1", ifa.ram_raddr, 0);
    drive(0, 0, 0, 0, 1);
    chk("browse_down2", ifa.ram_raddr, 7);
    drive(0, 0, 0, 1, 1);
    chk("browse_both", ifa.ram_raddr, 7);

    // Run 2: restart with a simultaneous step, then gappy stream with stray starts
    qa.delete();
    drive(1, 0, 0, 1, 0);
    chk("run2_restart_count", ifa.count, 0);
    chk("run2_restart_raddr", ifa.ram_raddr, 0);
    chk("run2_restart_busy", ifa.busy, 1);
    idx = 10;
    guard = 0;
    while (idx <= 21 && guard < 400) begin
      v  = ($urandom_range(0, 2) != 0);
      st = ($urandom_range(0, 3) == 0);
      up = ($urandom_range(0, 3) == 0);
      dn = ($urandom_range(0, 3) == 0);
      drive(st, v, v ? idx : int'($urandom_range(0, 255)), up, dn);
      if (v) idx++;
      guard++;
    end
    if (guard >= 400) begin
      n_cmp++;
      n_fail++;
      $display("FAIL run2_budget: got %0d samples, expected 12 within 400 cycles", idx - 10);
    end
    drive(0, 0, 0, 0, 0);
    check_log_a("run2", 14);
    chk("run2_done", ifa.done, 1);

    // Run 3: asynchronous reset after three writes
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, i, 0, 0);
    for (int i = 50; i < 53; i++) drive(0, 1, i, 0, 0);
    chk("run3_count_before_rst", ifa.count, 3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_we", ifa.ram_we, 0);
    chk("async_rst_waddr", ifa.ram_waddr, 0);
    chk("async_rst_wdata", ifa.ram_wdata, 0);
    chk("async_rst_raddr", ifa.ram_raddr, 0);
    chk("async_rst_count", ifa.count, 0);
    chk("async_rst_busy", ifa.busy, 0);
    chk("async_rst_done", ifa.done, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    qa.delete();
    for (int i = 60; i < 63; i++) drive(0, 1, i, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("post_rst_no_writes", qa.size(), 0);
    chk("post_rst_count", ifa.count, 0);

    // Run 4: zero warm-up, single-entry capture
    qb.delete();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 'hAB, 0, 0);
    chk("b_we", ifb.ram_we, 1);
    chk("b_waddr", ifb.ram_waddr, 0);
    chk("b_wdata", ifb.ram_wdata, 'hAB);
    chk("b_done", ifb.done, 1);
    drive(0, 1, 'hCD, 0, 0);
    chk("b_extra_we", ifb.ram_we, 0);
    chk("b_count", ifb.count, 1);
    drive(0, 0, 0, 0, 0);
    chk("b_nwrites", qb.size(), 1);
    if (qb.size() > 0) chk("b_write", qb[0], 'hAB);

    repeat (2) drive(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
